regfile_2r1w_param: RTL and testbench
=====================================

// Module: regfile_2r1w_param
// PURPOSE
//  Parametrised 2-read/1-write register file; successor to the fixed 8x32 register set in the CPU datapath.
//  Adds generic width/depth, write-to-read forwarding, and a sequenced bulk-clear engine with busy/done handshake.
//  Sits between decode (A1/A2 read addresses) and writeback (A3/WD3/WE3).
// PARAMETERS
//  WIDTH  32  data width of each register, in bits
//  DEPTH  32  number of registers; must be a power of two, >= 2
//  AW     $clog2(DEPTH)  address width; localparam, not overridable
// PORTS
//  CLK     in   1      single clock; all state updates on posedge
//  RST_N   in   1      synchronous reset, active-low
//  A1      in   AW     read port 1 address
//  A2      in   AW     read port 2 address
//  A3      in   AW     write address
//  WE3     in   1      write enable
//  WD3     in   WIDTH  write data
//  CLR     in   1      bulk-clear request; single-cycle pulse
//  RD1     out  WIDTH  read data, port 1 (combinational)
//  RD2     out  WIDTH  read data, port 2 (combinational)
//  BUSY    out  1      bulk clear in progress
//  DONE    out  1      1-cycle pulse on completion of bulk clear
//  WR_DROP out  1      1-cycle pulse: a write was rejected because BUSY was high
// BEHAVIOUR
//  Reset: one clock and reset only. RST_N low at a posedge clears all DEPTH registers to 0 in one cycle.
//   Reset also forces state to IDLE, clear pointer to 0, and BUSY/DONE/WR_DROP to 0.
//   Reset overrides any write, clear, or in-progress sweep in that cycle.
//  Write: WE3=1 in IDLE writes WD3 into reg[A3] at posedge. Write latency is 1 cycle.
//  Read: RD1=reg[A1] and RD2=reg[A2], combinational with 0-cycle latency.
//   Both ports may read the same address.
//  Forwarding: if WE3=1, BUSY=0 and A3==A1, then RD1=WD3 in the same cycle. The same rule applies to A2/RD2.
//   Forwarding is suppressed whenever BUSY=1.
//  Clear FSM:
//   - States IDLE and SWEEP.
//   - IDLE->SWEEP on CLR=1. That edge loads ptr=0; BUSY is high from the next cycle.
//   - In SWEEP, each posedge writes reg[ptr]=0 and then ptr++. A DEPTH-entry clear takes DEPTH cycles.
//   - When the edge writes ptr==DEPTH-1: go to IDLE, BUSY falls, DONE=1 for exactly one cycle.
//   - CLR while BUSY=1 is ignored; there is no restart.
//   - CLR and WE3 asserted in the same IDLE cycle: the write commits first, then the sweep erases it.
//  During SWEEP, WE3=1 is dropped (no register change) and WR_DROP pulses the next cycle.
//   Reads during SWEEP return stored contents: already-cleared entries read 0, later entries read old data.
//  ptr is AW bits wide and wraps naturally; no out-of-range address is possible since DEPTH=2^AW.
// CONFIGURATION
//  REGFILE_ZERO_REG_EN defined:
//   - reg[0] is hardwired zero; writes to A3=0 are discarded silently (no WR_DROP).
//   - RD1/RD2 return 0 for address 0, including when forwarding would apply.
//  REGFILE_ZERO_REG_EN undefined: reg[0] is an ordinary register with identical behaviour to all others.
// TESTING
//  1. Reset, then read all addresses -> RD1=RD2=0 for every address; BUSY=DONE=WR_DROP=0.
//  2. Write A3=5, WD3=0xDEADBEEF; next cycle A1=5, A2=5 -> RD1=RD2=0xDEADBEEF.
//  3. Same cycle WE3=1, A3=7, WD3=0x12345678, A1=7 -> RD1=0x12345678 before the edge (forwarding).
//  4. Fill all registers with index+1, pulse CLR -> BUSY high DEPTH cycles, DONE one pulse, all regs 0.
//     Mid-sweep, A1=DEPTH-1 still reads DEPTH.
//  5. WE3=1, A3=3 during SWEEP -> reg[3] ends 0 and WR_DROP pulses once.
//     RST_N=0 mid-sweep -> BUSY=0 next cycle, all regs 0, no DONE.
//  6. With REGFILE_ZERO_REG_EN: write A3=0, WD3=0xFFFFFFFF -> RD1 (A1=0) reads 0, same cycle and later.
//     Without the macro: reads 0xFFFFFFFF.

Source files
------------

// File: rtl/regfile_2r1w_param_if.sv
// ---------------------------------------------------------------------------
// regfile_2r1w_param_if
//   Bus bundle for the 2-read/1-write register file.
//   Decode drives A1/A2, writeback drives A3/WE3/WD3, control drives CLR.
//   The register file returns RD1/RD2 and the bulk-clear status BUSY/DONE,
//   plus WR_DROP when a write arrives during a clear sweep.
//
//   Parameters:
//     WIDTH : data width of each register
//     DEPTH : number of registers (power of two, >= 2)
//
//   Modports:
//     master : requester side (drives addresses, write data, clear request)
//     slave  : register file side (drives read data and status)
// ---------------------------------------------------------------------------
interface regfile_2r1w_param_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    A1;
    logic [AW-1:0]    A2;
    logic [AW-1:0]    A3;
    logic             WE3;
    logic [WIDTH-1:0] WD3;
    logic             CLR;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    logic             BUSY;
    logic             DONE;
    logic             WR_DROP;

    modport master (
        output A1, A2, A3, WE3, WD3, CLR,
        input  RD1, RD2, BUSY, DONE, WR_DROP
    );

    modport slave (
        input  A1, A2, A3, WE3, WD3, CLR,
        output RD1, RD2, BUSY, DONE, WR_DROP
    );
endinterface

// File: rtl/regfile_2r1w_param.sv
// ---------------------------------------------------------------------------
// regfile_2r1w_param
//   Parametrised register file with two combinational read ports, one
//   synchronous write port, write-to-read forwarding and a sequenced
//   bulk-clear engine (one entry per cycle) with BUSY/DONE handshake.
//
//   Parameters:
//     WIDTH : register width in bits
//     DEPTH : number of registers (power of two, >= 2)
//
//   Ports:
//     CLK   : clock, all state changes on posedge
//     RST_N : synchronous active-low reset; clears every register at once
//     bus   : regfile_2r1w_param_if.slave
//             A1/A2 read addresses, RD1/RD2 read data (0-cycle latency)
//             A3/WE3/WD3 write port (1-cycle latency)
//             CLR bulk-clear request, BUSY sweep in progress,
//             DONE completion pulse, WR_DROP rejected-write pulse
//
//   Optional feature macro: REGFILE_ZERO_REG_EN
//     When defined, register 0 is hardwired to zero: writes to address 0
//     are silently discarded and reads of address 0 always return 0.
//     When undefined, register 0 is an ordinary register.
//
//   Storage is built from flops rather than RAM because reset must clear
//   every entry in a single cycle and both read ports are combinational.
// ---------------------------------------------------------------------------
module regfile_2r1w_param #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    regfile_2r1w_param_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             done_q, done_d;
    logic             wr_drop_q, wr_drop_d;

    logic [WIDTH-1:0] reg_bank [DEPTH];
    logic             wr_addr_ok;
    logic             wr_commit;

    // Address 0 is not a writable target when the zero register is enabled.
    always_comb begin
`ifdef REGFILE_ZERO_REG_EN
        wr_addr_ok = (bus.A3 != '0);
`else
        wr_addr_ok = 1'b1;
`endif
    end

    // Writes only land while idle; the same term gates forwarding so a
    // forwarded value is always one that will actually be stored.
    assign wr_commit = (state_q == ST_IDLE) && bus.WE3 && wr_addr_ok;

    // ---------------- clear sequencer ----------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        done_d    = 1'b0;
        wr_drop_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.CLR) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end
            end
            ST_SWEEP: begin
                ptr_d     = ptr_q + 1'b1;
                wr_drop_d = bus.WE3 && wr_addr_ok;
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            done_q    <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            done_q    <= done_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // ---------------- storage ----------------
    // During a sweep the write port is locked out, so the clear and the
    // write can never target an entry in the same cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_q, entry_d;

        always_comb begin
            entry_d = entry_q;
            if ((state_q == ST_SWEEP) && (ptr_q == AW'(gi))) begin
                entry_d = '0;
            end else if (wr_commit && (bus.A3 == AW'(gi))) begin
                entry_d = bus.WD3;
            end
        end

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                entry_q <= '0;
            end else begin
                entry_q <= entry_d;
            end
        end

        assign reg_bank[gi] = entry_q;
    end

    // ---------------- read ports ----------------
    always_comb begin
        bus.RD1 = (wr_commit && (bus.A3 == bus.A1)) ? bus.WD3 : reg_bank[bus.A1];
        bus.RD2 = (wr_commit && (bus.A3 == bus.A2)) ? bus.WD3 : reg_bank[bus.A2];
`ifdef REGFILE_ZERO_REG_EN
        if (bus.A1 == '0) begin
            bus.RD1 = '0;
        end
        if (bus.A2 == '0) begin
            bus.RD2 = '0;
        end
`endif
    end

    assign bus.BUSY    = (state_q == ST_SWEEP);
    assign bus.DONE    = done_q;
    assign bus.WR_DROP = wr_drop_q;

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_2r1w_param
//   Self-checking bench for regfile_2r1w_param. A behavioural model (an
//   array of register values plus a "sweep in progress / entries cleared
//   so far" position) predicts read data and status; directed scenarios
//   cover the documented cases and a randomized phase mixes writes, reads
//   and clears. Build with +define+REGFILE_ZERO_REG_EN to cover the
//   zero-register variant.
// ---------------------------------------------------------------------------
module tb_regfile_2r1w_param;
    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = $clog2(D);
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_2r1w_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

    regfile_2r1w_param #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    logic [W-1:0] m_regs [D];
    bit           m_sweep;   // clear sweep in progress
    int           m_pos;     // entries below m_pos are already cleared
    bit           m_done;
    bit           m_drop;

    task automatic idle_inputs();
        bus.A1  = '0;
        bus.A2  = '0;
        bus.A3  = '0;
        bus.WE3 = 1'b0;
        bus.WD3 = '0;
        bus.CLR = 1'b0;
    endtask

    function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
        if (ZERO && a == '0) return '0;
        if (!m_sweep && bus.WE3 && bus.A3 == a && !(ZERO && bus.A3 == '0)) return bus.WD3;
        return m_regs[a];
    endfunction

    // Advance the model by one clock using the inputs currently applied,
    // then advance the simulation to just after the edge.
    task automatic tick();
        bit drop_n;
        bit done_n;
        bit wr_ok;
        drop_n = 1'b0;
        done_n = 1'b0;
        wr_ok  = bus.WE3 && !(ZERO && bus.A3 == '0);
        if (!rst_n) begin
            for (int i = 0; i < D; i++) m_regs[i] = '0;
            m_sweep = 1'b0;
            m_pos   = 0;
        end else if (m_sweep) begin
            drop_n        = wr_ok;
            m_regs[m_pos] = '0;
            m_pos++;
            if (m_pos == D) begin
                m_sweep = 1'b0;
                done_n  = 1'b1;
            end
        end else begin
            if (wr_ok) m_regs[bus.A3] = bus.WD3;
            if (bus.CLR) begin
                m_sweep = 1'b1;
                m_pos   = 0;
            end
        end
        @(posedge clk);
        #1;
        m_done = done_n;
        m_drop = drop_n;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.WE3 = 1'b1;
        bus.A3  = AW'(4);
        bus.WD3 = 32'hCAFEF00D;
        bus.CLR = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        idle_inputs();
        #1;
        n_checks++;
        if (bus.BUSY !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
        n_checks++;
        if (bus.DONE !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b exp=0", bus.DONE); end
        n_checks++;
        if (bus.WR_DROP !== 1'b0) begin n_errors++; $display("FAIL reset_wr_drop got=%b exp=0", bus.WR_DROP); end
        for (int a = 0; a < D; a++) begin
            bus.A1 = AW'(a);
            bus.A2 = AW'(D - 1 - a);
            #1;
            n_checks++;
            if (bus.RD1 !== 32'h0) begin n_errors++; $display("FAIL reset_rd1 a=%0d got=%h exp=0", a, bus.RD1); end
            n_checks++;
            if (bus.RD2 !== 32'h0) begin n_errors++; $display("FAIL reset_rd2 a=%0d got=%h exp=0", D - 1 - a, bus.RD2); end
        end
        $display("reset: all %0d entries read back", D);
    endtask

    task automatic test_write_read();
        bus.WE3 = 1'b1;
        bus.A3  = AW'(5);
        bus.WD3 = 32'hDEADBEEF;
        tick();
        idle_inputs();
        bus.A1 = AW'(5);
        bus.A2 = AW'(5);
        #1;
        n_checks++;
        if (bus.RD1 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wr_rd1 got=%h exp=deadbeef", bus.RD1); end
        n_checks++;
        if (bus.RD2 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL wr_rd2 got=%h exp=deadbeef", bus.RD2); end
        $display("write a3=5 wd3=deadbeef -> rd1=%h rd2=%h", bus.RD1, bus.RD2);
    endtask

    task automatic test_forward();
        bus.WE3 = 1'b1;
        bus.A3  = AW'(7);
        bus.WD3 = 32'h12345678;
        bus.A1  = AW'(7);
        bus.A2  = AW'(5);
        #1;
        n_checks++;
        if (bus.RD1 !== 32'h12345678) begin n_errors++; $display("FAIL fwd_rd1 got=%h exp=12345678", bus.RD1); end
        n_checks++;
        if (bus.RD2 !== 32'hDEADBEEF) begin n_errors++; $display("FAIL fwd_rd2_other got=%h exp=deadbeef", bus.RD2); end
        tick();
        bus.WE3 = 1'b0;
        #1;
        n_checks++;
        if (bus.RD1 !== 32'h12345678) begin n_errors++; $display("FAIL fwd_stored got=%h exp=12345678", bus.RD1); end
        $display("forward a3=7 wd3=12345678 -> rd1=%h", bus.RD1);
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        logic [W-1:0] exp;
        exp = ZERO ? 32'h0 : 32'hFFFFFFFF;
        bus.WE3 = 1'b1;
        bus.A3  = '0;
        bus.WD3 = 32'hFFFFFFFF;
        bus.A1  = '0;
        bus.A2  = '0;
        #1;
        n_checks++;
        if (bus.RD1 !== exp) begin n_errors++; $display("FAIL zero_same_cycle got=%h exp=%h", bus.RD1, exp); end
        tick();
        bus.WE3 = 1'b0;
        #1;
        n_checks++;
        if (bus.RD1 !== exp) begin n_errors++; $display("FAIL zero_rd1_later got=%h exp=%h", bus.RD1, exp); end
        n_checks++;
        if (bus.RD2 !== exp) begin n_errors++; $display("FAIL zero_rd2_later got=%h exp=%h", bus.RD2, exp); end
        n_checks++;
        if (bus.WR_DROP !== 1'b0) begin n_errors++; $display("FAIL zero_no_drop got=%b exp=0", bus.WR_DROP); end
        $display("write a3=0 wd3=ffffffff -> rd1=%h", bus.RD1);
        idle_inputs();
    endtask

    task automatic fill_index_plus_one();
        for (int i = 0; i < D; i++) begin
            bus.WE3 = 1'b1;
            bus.A3  = AW'(i);
            bus.WD3 = W'(i + 1);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_sweep();
        int busy_cycles;
        int done_cnt;
        int drop_cnt;
        fill_index_plus_one();
        bus.CLR = 1'b1;
        tick();
        bus.CLR = 1'b0;
        busy_cycles = 0;
        done_cnt    = 0;
        drop_cnt    = 0;
        for (int cyc = 0; cyc < D + 8; cyc++) begin
            // A write to an already-cleared entry must be dropped, and its
            // value must not be forwarded to a read of the same address.
            bus.WE3 = (cyc == 5);
            bus.A3  = AW'(3);
            bus.WD3 = 32'hAAAA5555;
            bus.A1  = (cyc == 5) ? AW'(3) : AW'(D - 1);
            #1;
            if (bus.BUSY)    busy_cycles++;
            if (bus.DONE)    done_cnt++;
            if (bus.WR_DROP) drop_cnt++;
            if (cyc == 5) begin
                n_checks++;
                if (bus.RD1 !== 32'h0) begin n_errors++; $display("FAIL sweep_no_fwd got=%h exp=0", bus.RD1); end
            end
            if (cyc == D / 2) begin
                n_checks++;
                if (bus.RD1 !== W'(D)) begin n_errors++; $display("FAIL sweep_mid_old got=%h exp=%h", bus.RD1, W'(D)); end
            end
            tick();
        end
        idle_inputs();
        n_checks++;
        if (busy_cycles != D) begin n_errors++; $display("FAIL sweep_busy_len got=%0d exp=%0d", busy_cycles, D); end
        n_checks++;
        if (done_cnt != 1) begin n_errors++; $display("FAIL sweep_done_pulses got=%0d exp=1", done_cnt); end
        n_checks++;
        if (drop_cnt != 1) begin n_errors++; $display("FAIL sweep_drop_pulses got=%0d exp=1", drop_cnt); end
        for (int a = 0; a < D; a++) begin
            bus.A1 = AW'(a);
            bus.A2 = AW'(a);
            #1;
            n_checks++;
            if (bus.RD1 !== 32'h0) begin n_errors++; $display("FAIL sweep_cleared a=%0d got=%h exp=0", a, bus.RD1); end
        end
        $display("sweep: busy=%0d cycles done=%0d drop=%0d", busy_cycles, done_cnt, drop_cnt);
    endtask

    task automatic test_clr_with_write();
        int guard;
        bus.WE3 = 1'b1;
        bus.A3  = AW'(9);
        bus.WD3 = 32'h5A5A5A5A;
        bus.CLR = 1'b1;
        tick();
        idle_inputs();
        bus.A1 = AW'(9);
        #1;
        n_checks++;
        if (bus.RD1 !== 32'h5A5A5A5A) begin n_errors++; $display("FAIL clrwr_committed got=%h exp=5a5a5a5a", bus.RD1); end
        guard = 0;
        while (bus.BUSY === 1'b1 && guard < D + 4) begin
            tick();
            guard++;
        end
        n_checks++;
        if (bus.BUSY !== 1'b0) begin n_errors++; $display("FAIL clrwr_timeout busy=%b exp=0", bus.BUSY); end
        n_checks++;
        if (bus.RD1 !== 32'h0) begin n_errors++; $display("FAIL clrwr_erased got=%h exp=0", bus.RD1); end
        $display("clr+write a3=9: after sweep rd1=%h", bus.RD1);
    endtask

    task automatic test_random(input int n);
        for (int c = 0; c < n; c++) begin
            bus.A1  = AW'($urandom_range(0, D - 1));
            bus.A2  = AW'($urandom_range(0, D - 1));
            bus.A3  = ($urandom_range(0, 3) == 0) ? bus.A1 : AW'($urandom_range(0, D - 1));
            bus.WE3 = 1'($urandom_range(0, 1));
            bus.WD3 = $urandom;
            bus.CLR = ($urandom_range(0, 39) == 0);
            #1;
            n_checks++;
            if (bus.RD1 !== exp_rd(bus.A1)) begin n_errors++; $display("FAIL rnd_rd1 c=%0d a1=%0d got=%h exp=%h", c, bus.A1, bus.RD1, exp_rd(bus.A1)); end
            n_checks++;
            if (bus.RD2 !== exp_rd(bus.A2)) begin n_errors++; $display("FAIL rnd_rd2 c=%0d a2=%0d got=%h exp=%h", c, bus.A2, bus.RD2, exp_rd(bus.A2)); end
            n_checks++;
            if (bus.BUSY !== m_sweep) begin n_errors++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, bus.BUSY, m_sweep); end
            n_checks++;
            if (bus.DONE !== m_done) begin n_errors++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, bus.DONE, m_done); end
            n_checks++;
            if (bus.WR_DROP !== m_drop) begin n_errors++; $display("FAIL rnd_drop c=%0d got=%b exp=%b", c, bus.WR_DROP, m_drop); end
            $display("txn %0d we=%b a3=%0d wd3=%h clr=%b a1=%0d rd1=%h busy=%b", c, bus.WE3, bus.A3, bus.WD3, bus.CLR, bus.A1, bus.RD1, bus.BUSY);
            tick();
        end
        idle_inputs();
        // Let any sweep started in the random phase run out.
        for (int k = 0; k < D + 2 && m_sweep; k++) tick();
    endtask

    task automatic test_reset_mid_sweep();
        fill_index_plus_one();
        bus.CLR = 1'b1;
        tick();
        bus.CLR = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (bus.BUSY !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.BUSY); end
        for (int k = 0; k < D + 2; k++) begin
            bus.A1 = AW'(k % D);
            bus.A2 = AW'(D - 1 - (k % D));
            #1;
            n_checks++;
            if (bus.DONE !== 1'b0) begin n_errors++; $display("FAIL rstmid_done k=%0d got=%b exp=0", k, bus.DONE); end
            n_checks++;
            if (bus.RD1 !== 32'h0) begin n_errors++; $display("FAIL rstmid_rd1 a=%0d got=%h exp=0", k % D, bus.RD1); end
            n_checks++;
            if (bus.RD2 !== 32'h0) begin n_errors++; $display("FAIL rstmid_rd2 a=%0d got=%h exp=0", D - 1 - (k % D), bus.RD2); end
            tick();
        end
        $display("reset mid-sweep: busy=%b after reset", bus.BUSY);
    endtask

    initial begin
        rst_n   = 1'b0;
        m_sweep = 1'b0;
        m_pos   = 0;
        m_done  = 1'b0;
        m_drop  = 1'b0;
        for (int i = 0; i < D; i++) m_regs[i] = '0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_forward();
        test_zero_reg();
        test_sweep();
        test_clr_with_write();
        test_random(300);
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
